// File: rtl/kmeans_iter_ctrl_if.sv
// Host/datapath bundle for kmeans_iter_ctrl. The iter_cycles/total_cycles perf outputs
// exist only when KMEANS_ITER_PERF_EN is defined.
interface kmeans_iter_ctrl_if #(
  parameter int ITER_BITS = 16,
  parameter int ADDR_BITS = 64
);
  logic                 start;
  logic                 abort;
  logic [ITER_BITS-1:0] num_iteration;
  logic [7:0]           num_cluster;
  logic [15:0]          data_dim;
  logic [31:0]          tuple_lines;
  logic [ADDR_BITS-1:0] cent_base;
  logic [ADDR_BITS-1:0] result_base;
  logic                 start_operator;
  logic                 um_done;
  logic                 cent_req_valid;
  logic                 cent_req_ready;
  logic [ADDR_BITS-1:0] cent_req_addr;
  logic [31:0]          cent_req_lines;
  logic                 tuple_req_valid;
  logic                 tuple_req_ready;
  logic [31:0]          tuple_req_lines;
  logic                 updated_centroid_valid;
  logic                 updated_centroid_last;
  logic                 wr_valid;
  logic [ADDR_BITS-1:0] wr_addr;
  logic                 busy;
  logic                 done;
  logic                 err_len;
  logic [ITER_BITS-1:0] iter_cnt;
`ifdef KMEANS_ITER_PERF_EN
  logic [31:0]          iter_cycles;
  logic [31:0]          total_cycles;
`endif

  modport master (
`ifdef KMEANS_ITER_PERF_EN
    input  iter_cycles, total_cycles,
`endif
    output start, abort, num_iteration, num_cluster, data_dim, tuple_lines, cent_base,
           result_base, cent_req_ready, tuple_req_ready, updated_centroid_valid,
           updated_centroid_last,
    input  start_operator, um_done, cent_req_valid, cent_req_addr, cent_req_lines,
           tuple_req_valid, tuple_req_lines, wr_valid, wr_addr, busy, done, err_len, iter_cnt
  );

  modport slave (
`ifdef KMEANS_ITER_PERF_EN
    output iter_cycles, total_cycles,
`endif
    input  start, abort, num_iteration, num_cluster, data_dim, tuple_lines, cent_base,
           result_base, cent_req_ready, tuple_req_ready, updated_centroid_valid,
           updated_centroid_last,
    output start_operator, um_done, cent_req_valid, cent_req_addr, cent_req_lines,
           tuple_req_valid, tuple_req_lines, wr_valid, wr_addr, busy, done, err_len, iter_cnt
  );
endinterface

// File: rtl/kmeans_iter_ctrl.sv
// K-means iteration sequencer: one centroid fetch, then tuple pass + update write-back per
// iteration. Optional cycle counters enabled by the KMEANS_ITER_PERF_EN macro.
//
// state   | meaning
// S_IDLE  | waiting for start
// S_CENT  | centroid fetch request outstanding (once per job)
// S_TUPLE | tuple pass request outstanding
// S_WAIT  | collecting updated centroid lines for this iteration
// S_FIN   | one-cycle wrap-up: um_done, done unless aborted
module kmeans_iter_ctrl #(
  parameter int ITER_BITS = 16,
  parameter int ADDR_BITS = 64
) (
  input logic               clk,
  input logic               rst_n,
  kmeans_iter_ctrl_if.slave ctrl_if
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CENT  = 3'd1;
  localparam logic [2:0] S_TUPLE = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  logic [2:0]           state_q, state_d;
  logic [ITER_BITS-1:0] num_iter_q, num_iter_d;
  logic [ITER_BITS-1:0] iter_cnt_q, iter_cnt_d;
  logic [31:0]          tuple_lines_q, tuple_lines_d;
  logic [31:0]          cent_lines_q, cent_lines_d;
  logic [31:0]          line_idx_q, line_idx_d;
  logic [ADDR_BITS-1:0] cent_base_q, cent_base_d;
  logic [ADDR_BITS-1:0] result_base_q, result_base_d;
  logic [ADDR_BITS-1:0] iter_base_q, iter_base_d;
  logic [ADDR_BITS-1:0] wr_addr_q, wr_addr_d;
  logic                 start_op_q, start_op_d;
  logic                 um_done_q, um_done_d;
  logic                 done_q, done_d;
  logic                 err_len_q, err_len_d;
  logic                 wr_valid_q, wr_valid_d;
  logic                 aborted_q, aborted_d;

  logic [23:0]          cent_prod;
  logic [24:0]          cent_round;
  logic [31:0]          cent_lines_calc;
  logic                 job_start;
  logic                 abort_take;
  logic                 upd_take;
  logic                 iter_end;

  assign cent_prod       = 24'(ctrl_if.num_cluster) * 24'(ctrl_if.data_dim);
  assign cent_round      = {1'b0, cent_prod} + 25'd15;
  assign cent_lines_calc = {11'd0, cent_round[24:4]};

  assign job_start  = (state_q == S_IDLE) && ctrl_if.start;
  assign abort_take = ctrl_if.abort &&
                      ((state_q == S_CENT) || (state_q == S_TUPLE) || (state_q == S_WAIT));
  assign upd_take   = (state_q == S_WAIT) && !ctrl_if.abort && ctrl_if.updated_centroid_valid;
  assign iter_end   = upd_take && ctrl_if.updated_centroid_last;

  always_comb begin
    state_d       = state_q;
    num_iter_d    = num_iter_q;
    iter_cnt_d    = iter_cnt_q;
    tuple_lines_d = tuple_lines_q;
    cent_lines_d  = cent_lines_q;
    line_idx_d    = line_idx_q;
    cent_base_d   = cent_base_q;
    result_base_d = result_base_q;
    iter_base_d   = iter_base_q;
    wr_addr_d     = wr_addr_q;
    done_d        = done_q;
    err_len_d     = err_len_q;
    aborted_d     = aborted_q;
    start_op_d    = 1'b0;
    um_done_d     = 1'b0;
    wr_valid_d    = 1'b0;

    if (job_start) begin
      num_iter_d    = ctrl_if.num_iteration;
      tuple_lines_d = ctrl_if.tuple_lines;
      cent_base_d   = ctrl_if.cent_base;
      result_base_d = ctrl_if.result_base;
      cent_lines_d  = cent_lines_calc;
      iter_cnt_d    = '0;
      line_idx_d    = '0;
      iter_base_d   = '0;
      done_d        = 1'b0;
      err_len_d     = 1'b0;
      aborted_d     = 1'b0;
      start_op_d    = 1'b1;
      state_d       = (ctrl_if.num_iteration == '0) ? S_FIN : S_CENT;
    end else if (abort_take) begin
      aborted_d = 1'b1;
      state_d   = S_FIN;
    end else begin
      case (state_q)
        S_CENT:  if (ctrl_if.cent_req_ready) state_d = S_TUPLE;
        S_TUPLE: if (ctrl_if.tuple_req_ready) state_d = S_WAIT;
        S_WAIT: begin
          if (upd_take) begin
            // iter_base tracks iter_cnt*cent_lines incrementally, so no multiplier is needed
            wr_valid_d = 1'b1;
            wr_addr_d  = result_base_q + iter_base_q + ADDR_BITS'(line_idx_q);
            if (ctrl_if.updated_centroid_last) begin
              line_idx_d  = '0;
              if (line_idx_q + 32'd1 != cent_lines_q) err_len_d = 1'b1;
              iter_cnt_d  = iter_cnt_q + 1'b1;
              iter_base_d = iter_base_q + ADDR_BITS'(cent_lines_q);
              state_d     = (iter_cnt_d == num_iter_q) ? S_FIN : S_TUPLE;
            end else begin
              line_idx_d = line_idx_q + 32'd1;
            end
          end
        end
        S_FIN: begin
          um_done_d = 1'b1;
          done_d    = !(aborted_q || ctrl_if.abort);
          state_d   = S_IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      num_iter_q    <= '0;
      iter_cnt_q    <= '0;
      tuple_lines_q <= '0;
      cent_lines_q  <= '0;
      line_idx_q    <= '0;
      cent_base_q   <= '0;
      result_base_q <= '0;
      iter_base_q   <= '0;
      wr_addr_q     <= '0;
      start_op_q    <= 1'b0;
      um_done_q     <= 1'b0;
      done_q        <= 1'b0;
      err_len_q     <= 1'b0;
      wr_valid_q    <= 1'b0;
      aborted_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      num_iter_q    <= num_iter_d;
      iter_cnt_q    <= iter_cnt_d;
      tuple_lines_q <= tuple_lines_d;
      cent_lines_q  <= cent_lines_d;
      line_idx_q    <= line_idx_d;
      cent_base_q   <= cent_base_d;
      result_base_q <= result_base_d;
      iter_base_q   <= iter_base_d;
      wr_addr_q     <= wr_addr_d;
      start_op_q    <= start_op_d;
      um_done_q     <= um_done_d;
      done_q        <= done_d;
      err_len_q     <= err_len_d;
      wr_valid_q    <= wr_valid_d;
      aborted_q     <= aborted_d;
    end
  end

  assign ctrl_if.start_operator  = start_op_q;
  assign ctrl_if.um_done         = um_done_q;
  assign ctrl_if.cent_req_valid  = (state_q == S_CENT);
  assign ctrl_if.cent_req_addr   = cent_base_q;
  assign ctrl_if.cent_req_lines  = cent_lines_q;
  assign ctrl_if.tuple_req_valid = (state_q == S_TUPLE);
  assign ctrl_if.tuple_req_lines = tuple_lines_q;
  assign ctrl_if.wr_valid        = wr_valid_q;
  assign ctrl_if.wr_addr         = wr_addr_q;
  assign ctrl_if.busy            = (state_q != S_IDLE);
  assign ctrl_if.done            = done_q;
  assign ctrl_if.err_len         = err_len_q;
  assign ctrl_if.iter_cnt        = iter_cnt_q;

`ifdef KMEANS_ITER_PERF_EN
  logic [31:0] iter_cyc_q, iter_cycles_q, total_cyc_q, total_cycles_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iter_cyc_q     <= '0;
      iter_cycles_q  <= '0;
      total_cyc_q    <= '0;
      total_cycles_q <= '0;
    end else if (job_start) begin
      iter_cyc_q  <= '0;
      total_cyc_q <= '0;
    end else begin
      if (state_q != S_IDLE) total_cyc_q <= total_cyc_q + 32'd1;
      if (state_q == S_FIN) total_cycles_q <= total_cyc_q + 32'd1;
      if (iter_end) begin
        iter_cycles_q <= iter_cyc_q + 32'd1;
        iter_cyc_q    <= '0;
      end else if ((state_q == S_TUPLE) || (state_q == S_WAIT)) begin
        iter_cyc_q <= iter_cyc_q + 32'd1;
      end
    end
  end

  assign ctrl_if.iter_cycles  = iter_cycles_q;
  assign ctrl_if.total_cycles = total_cycles_q;
`endif
endmodule
